// File: rtl/frame_ram_arbiter.sv
// Read-priority arbiter sharing a single-port frame RAM between the VGA reader and a buffered
// pixel writer. Define FRAME_STATUS_EN to enable the frame_done pulse and frame_cnt counter.
module frame_ram_arbiter #(
    parameter int unsigned PIXEL_COUNT = 172800,
    parameter int unsigned DATA_W      = 24,
    parameter int unsigned FIFO_DEPTH  = 4,
    localparam int unsigned ADDR_W     = $clog2(PIXEL_COUNT)
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_wr_req,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [DATA_W-1:0] i_wr_data,
    output logic              o_wr_full,
    output logic              o_overflow,
    input  logic              i_rd_req,
    input  logic [ADDR_W-1:0] i_rd_addr,
    output logic              o_rd_valid,
    output logic [DATA_W-1:0] o_rd_data,
    output logic [ADDR_W-1:0] o_ram_addr,
    output logic              o_ram_we,
    output logic [DATA_W-1:0] o_ram_wdata,
    input  logic [DATA_W-1:0] i_ram_rdata,
    output logic              o_frame_done,
    output logic [7:0]        o_frame_cnt
);
    localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W  = PTR_W + 1;
    localparam int unsigned AEXT_W = ADDR_W + 1;
    localparam int unsigned ENT_W  = ADDR_W + DATA_W;
    localparam logic [AEXT_W-1:0] PIX_EXT = AEXT_W'(PIXEL_COUNT);

    typedef enum logic [1:0] {G_IDLE, G_RD, G_WR} grant_e;

    grant_e            r_grant;
    grant_e            w_grant;
    logic [ENT_W-1:0]  r_fifo [FIFO_DEPTH];
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [CNT_W-1:0]  r_count;
    logic [ADDR_W-1:0] r_ram_addr;
    logic              r_ram_we;
    logic [DATA_W-1:0] r_ram_wdata;
    logic              r_rd_oob1;
    logic              r_rd_oob2;
    logic              r_rd_valid;
    logic              r_overflow;

    logic              w_pop;
    logic              w_push;
    logic              w_full;
    logic [ENT_W-1:0]  w_head;
    logic [ADDR_W-1:0] w_head_addr;
    logic [DATA_W-1:0] w_head_data;
    logic              w_head_oob;
    logic              w_rd_oob;

    // Grant is decided fresh every cycle from the current request and FIFO occupancy.
    always_comb begin
        w_grant = G_IDLE;
        if (i_rd_req) begin
            w_grant = G_RD;
        end else if (r_count != '0) begin
            w_grant = G_WR;
        end
    end

    assign w_full      = (r_count == CNT_W'(FIFO_DEPTH));
    assign w_pop       = (w_grant == G_WR);
    assign w_push      = i_wr_req && (!w_full || w_pop);
    assign w_head      = r_fifo[r_rd_ptr];
    assign w_head_addr = w_head[ENT_W-1:DATA_W];
    assign w_head_data = w_head[DATA_W-1:0];
    assign w_head_oob  = ({1'b0, w_head_addr} >= PIX_EXT);
    assign w_rd_oob    = ({1'b0, i_rd_addr} >= PIX_EXT);

    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_fifo[r_wr_ptr] <= {i_wr_addr, i_wr_data};
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_grant     <= G_IDLE;
            r_rd_ptr    <= '0;
            r_wr_ptr    <= '0;
            r_count     <= '0;
            r_ram_addr  <= '0;
            r_ram_we    <= 1'b0;
            r_ram_wdata <= '0;
            r_rd_oob1   <= 1'b0;
            r_rd_oob2   <= 1'b0;
            r_rd_valid  <= 1'b0;
            r_overflow  <= 1'b0;
        end else begin
            r_grant    <= w_grant;
            r_ram_we   <= 1'b0;
            r_rd_oob1  <= w_rd_oob;
            r_rd_oob2  <= r_rd_oob1;
            r_rd_valid <= (r_grant == G_RD);
            if (w_grant == G_RD && !w_rd_oob) begin
                r_ram_addr <= i_rd_addr;
            end
            // Out-of-range entries are consumed without touching the RAM port.
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
                if (!w_head_oob) begin
                    r_ram_addr  <= w_head_addr;
                    r_ram_wdata <= w_head_data;
                    r_ram_we    <= 1'b1;
                end
            end
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
            if (i_wr_req && !w_push) begin
                r_overflow <= 1'b1;
            end
        end
    end

    assign o_wr_full   = w_full;
    assign o_overflow  = r_overflow;
    assign o_rd_valid  = r_rd_valid;
    assign o_rd_data   = (r_rd_valid && !r_rd_oob2) ? i_ram_rdata : '0;
    assign o_ram_addr  = r_ram_addr;
    assign o_ram_we    = r_ram_we;
    assign o_ram_wdata = r_ram_wdata;

`ifdef FRAME_STATUS_EN
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(PIXEL_COUNT - 1);

    logic       r_frame_done;
    logic [7:0] r_frame_cnt;
    logic       w_last_wr;

    assign w_last_wr = w_pop && (w_head_addr == LAST_ADDR);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_frame_done <= 1'b0;
            r_frame_cnt  <= '0;
        end else begin
            r_frame_done <= w_last_wr;
            if (w_last_wr) begin
                r_frame_cnt <= r_frame_cnt + 8'd1;
            end
        end
    end

    assign o_frame_done = r_frame_done;
    assign o_frame_cnt  = r_frame_cnt;
`else
    assign o_frame_done = 1'b0;
    assign o_frame_cnt  = '0;
`endif

endmodule

// File: tb/tb_frame_ram_arbiter.sv
// Bench for frame_ram_arbiter: directed scenarios plus random traffic, checked against a
// queue-based reference model and a behavioural RAM.
module tb_frame_ram_arbiter;
    localparam int PC = 172800;
    localparam int DW = 24;
    localparam int FD = 4;
    localparam int AW = 18;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          wr_req = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [DW-1:0] wr_data = '0;
    logic          wr_full;
    logic          overflow;
    logic          rd_req = 1'b0;
    logic [AW-1:0] rd_addr = '0;
    logic          rd_valid;
    logic [DW-1:0] rd_data;
    logic [AW-1:0] ram_addr;
    logic          ram_we;
    logic [DW-1:0] ram_wdata;
    logic [DW-1:0] ram_rdata;
    logic          frame_done;
    logic [7:0]    frame_cnt;

    frame_ram_arbiter #(.PIXEL_COUNT(PC), .DATA_W(DW), .FIFO_DEPTH(FD)) dut (
        .i_clk(clk), .i_reset(reset),
        .i_wr_req(wr_req), .i_wr_addr(wr_addr), .i_wr_data(wr_data),
        .o_wr_full(wr_full), .o_overflow(overflow),
        .i_rd_req(rd_req), .i_rd_addr(rd_addr),
        .o_rd_valid(rd_valid), .o_rd_data(rd_data),
        .o_ram_addr(ram_addr), .o_ram_we(ram_we), .o_ram_wdata(ram_wdata),
        .i_ram_rdata(ram_rdata),
        .o_frame_done(frame_done), .o_frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;

    // Behavioural single-port RAM with one cycle of read latency.
    logic [DW-1:0] ram_mem [0:PC-1];
    always @(posedge clk) begin
        if (ram_we) ram_mem[ram_addr] <= ram_wdata;
        ram_rdata <= ram_mem[ram_addr];
    end

    // Reference model state: pending writes, expected RAM image, expected pipeline events.
    logic [DW-1:0]       ref_mem [0:PC-1];
    logic [AW+DW-1:0]    pend [$];
    bit                  exp_we;
    logic [AW-1:0]       exp_wa;
    logic [DW-1:0]       exp_wd;
    bit                  rd1_v, rd1_oob, rd2_v, rd2_oob;
    logic [AW-1:0]       rd1_a, rd2_a;
    bit                  ovf;
    int                  fcnt;
    int                  n_tests = 0;
    int                  n_fail = 0;

    function automatic bit is_oob(input logic [AW-1:0] a);
        return int'({14'd0, a}) >= PC;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        bit            fd;
        logic [DW-1:0] rexp;
        chk("rd_valid", 64'(rd_valid), 64'(rd2_v));
        if (rd2_v) begin
            rexp = rd2_oob ? '0 : ref_mem[rd2_a];
            chk("rd_data", 64'(rd_data), 64'(rexp));
        end
        chk("ram_we", 64'(ram_we), 64'(exp_we));
        if (exp_we) begin
            chk("ram_addr_wr", 64'(ram_addr), 64'(exp_wa));
            chk("ram_wdata", 64'(ram_wdata), 64'(exp_wd));
            ref_mem[exp_wa] = exp_wd;
        end else if (rd1_v && !rd1_oob) begin
            chk("ram_addr_rd", 64'(ram_addr), 64'(rd1_a));
        end
        chk("wr_full", 64'(wr_full), 64'(pend.size() == FD));
        chk("overflow", 64'(overflow), 64'(ovf));
`ifdef FRAME_STATUS_EN
        fd = exp_we && (int'({14'd0, exp_wa}) == PC - 1);
`else
        fd = 1'b0;
`endif
        if (fd) fcnt++;
        chk("frame_done", 64'(frame_done), 64'(fd));
        chk("frame_cnt", 64'(frame_cnt), 64'(fcnt % 256));
    endtask

    // One clock cycle of stimulus; the model applies the arbitration rules to decide outcomes.
    task automatic step(input bit rd, input logic [AW-1:0] ra, input bit wr,
                        input logic [AW-1:0] wa, input logic [DW-1:0] wd);
        bit               n_we = 1'b0;
        logic [AW+DW-1:0] e;
        rd_req = rd; rd_addr = ra; wr_req = wr; wr_addr = wa; wr_data = wd;
        if (!rd && pend.size() > 0) begin
            e = pend.pop_front();
            n_we = !is_oob(e[AW+DW-1:DW]);
        end
        if (wr) begin
            if (pend.size() < FD) pend.push_back({wa, wd});
            else ovf = 1'b1;
        end
        @(posedge clk);
        #1;
        rd2_v = rd1_v; rd2_oob = rd1_oob; rd2_a = rd1_a;
        rd1_v = rd; rd1_oob = is_oob(ra); rd1_a = ra;
        exp_we = n_we; exp_wa = e[AW+DW-1:DW]; exp_wd = e[DW-1:0];
        check_outputs();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, '0, '0);
    endtask

    task automatic do_reset();
        reset = 1'b1; rd_req = 1'b0; wr_req = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("rst_ram_we", 64'(ram_we), 64'd0);
        chk("rst_ram_addr", 64'(ram_addr), 64'd0);
        chk("rst_ram_wdata", 64'(ram_wdata), 64'd0);
        chk("rst_rd_valid", 64'(rd_valid), 64'd0);
        chk("rst_rd_data", 64'(rd_data), 64'd0);
        chk("rst_wr_full", 64'(wr_full), 64'd0);
        chk("rst_overflow", 64'(overflow), 64'd0);
        chk("rst_frame", 64'({frame_done, frame_cnt}), 64'd0);
        reset = 1'b0;
        pend.delete();
        exp_we = 1'b0; rd1_v = 1'b0; rd2_v = 1'b0; ovf = 1'b0; fcnt = 0;
    endtask

    initial begin
        logic [AW-1:0] a;
        bit            rd_on;
        int            exp_frames;

        do_reset();

        // Idle write lands on the RAM port two cycles after the request.
        step(1'b0, '0, 1'b1, 18'd5, 24'h112233);
        idle(1);
        chk("t1_we", 64'(ram_we), 64'd1);
        chk("t1_addr", 64'(ram_addr), 64'd5);
        chk("t1_data", 64'(ram_wdata), 64'h112233);
        idle(2);

        // Preload addresses 0..15 so every later read targets known contents.
        for (int i = 0; i < 16; i++) begin
            step(1'b0, '0, 1'b1, AW'(i), (i < 3) ? DW'(10 + i) : DW'($urandom));
        end
        idle(3);

        // Back-to-back reads with fixed two-cycle latency.
        step(1'b1, 18'd0, 1'b0, '0, '0);
        chk("t2_lat", 64'(rd_valid), 64'd0);
        step(1'b1, 18'd1, 1'b0, '0, '0);
        chk("t2_d0", 64'(rd_data), 64'hA);
        step(1'b1, 18'd2, 1'b0, '0, '0);
        chk("t2_d1", 64'(rd_data), 64'hB);
        idle(1);
        chk("t2_d2", 64'(rd_data), 64'hC);
        idle(2);

        // Writes buffer behind a held read and drain in order once it drops.
        for (int i = 0; i < 10; i++) begin
            step(1'b1, AW'(i), (i % 3 == 1), AW'(20 + i), DW'($urandom));
            chk("t3_no_we", 64'(ram_we), 64'd0);
        end
        idle(5);

        // Fifth write into a full FIFO is dropped and overflow sticks.
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 18'd3, 1'b1, AW'(30 + i), DW'($urandom));
            if (i == 3) chk("t4_full", 64'(wr_full), 64'd1);
        end
        chk("t4_ovf", 64'(overflow), 64'd1);
        idle(8);
        chk("t4_ovf_sticky", 64'(overflow), 64'd1);
        do_reset();

        // Out-of-range write and read; reset discards pending writes.
        step(1'b0, '0, 1'b1, AW'(PC), 24'hDEAD01);
        idle(3);
        step(1'b1, AW'(PC), 1'b0, '0, '0);
        idle(1);
        chk("t5_oob_valid", 64'(rd_valid), 64'd1);
        chk("t5_oob_data", 64'(rd_data), 64'd0);
        idle(2);
        step(1'b1, 18'd4, 1'b1, 18'd40, 24'h404040);
        step(1'b1, 18'd5, 1'b1, 18'd41, 24'h414141);
        do_reset();
        idle(4);

        // Last-pixel writes drive the frame status outputs.
        step(1'b0, '0, 1'b1, AW'(PC - 1), 24'h777777);
        step(1'b0, '0, 1'b1, AW'(PC - 1), 24'h888888);
        idle(3);
`ifdef FRAME_STATUS_EN
        exp_frames = 2;
`else
        exp_frames = 0;
`endif
        chk("t6_cnt", 64'(frame_cnt), 64'(exp_frames));

        // Random mixed traffic.
        rd_on = 1'b0;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 7) == 0) rd_on = !rd_on;
            a = ($urandom_range(0, 15) == 0) ? AW'(PC + $urandom_range(0, 89343))
                                             : AW'($urandom_range(0, 15));
            step(rd_on, a, ($urandom_range(0, 9) < 4),
                 ($urandom_range(0, 19) == 0) ? AW'(PC - 1) :
                 ($urandom_range(0, 19) == 0) ? AW'(PC + 7) : AW'($urandom_range(0, 15)),
                 DW'($urandom));
        end
        idle(8);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
